// File: rtl/periph_arbiter.sv
// periph_arbiter: shares one peripheral instruction bus between two sequencer
// requesters. Each requester owns a 1-entry holding register. Held commands are
// issued round-robin, and a command whose target device is busy is skipped.
// Optional feature macro: PERIPH_ARBITER_LOCK_EN enables the bus lock FSM
// (UNLOCKED / LOCKED0 / LOCKED1) driven by the per-command lock bit.
module periph_arbiter #(
   parameter int INST_WIDTH = 12,
   parameter int NUM_DEV    = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic [INST_WIDTH-1:0] req0_inst,
   input  logic [2:0]            req0_dev,
   input  logic                  req0_lock,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [INST_WIDTH-1:0] req1_inst,
   input  logic [2:0]            req1_dev,
   input  logic                  req1_lock,
   output logic                  req1_ready,
   input  logic [NUM_DEV-1:0]    dev_busy,
   output logic [INST_WIDTH-1:0] oreg,
   output logic [NUM_DEV-1:0]    oreg_wen,
   output logic [1:0]            grant
);

   // Holding registers, one per requester
   logic                  r_hold0Valid;
   logic [INST_WIDTH-1:0] r_hold0Inst;
   logic [2:0]            r_hold0Dev;
   logic                  r_hold1Valid;
   logic [INST_WIDTH-1:0] r_hold1Inst;
   logic [2:0]            r_hold1Dev;

   // Arbitration state and registered bus outputs
   logic                  r_rrPtr;
   logic [INST_WIDTH-1:0] r_oreg;
   logic [NUM_DEV-1:0]    r_oregWen;
   logic [1:0]            r_grant;

   // Combinational arbitration results
   logic                  w_elig0;
   logic                  w_elig1;
   logic                  w_allow0;
   logic                  w_allow1;
   logic                  w_ptrFreeze;
   logic                  w_cand0;
   logic                  w_cand1;
   logic                  w_win0;
   logic                  w_win1;
   logic                  w_issue;
   logic [INST_WIDTH-1:0] w_winInst;
   logic [2:0]            w_winDev;
   logic [NUM_DEV-1:0]    w_winWen;

   // Ready is purely a function of the holding register, never of valid
   assign req0_ready = !r_hold0Valid;
   assign req1_ready = !r_hold1Valid;

   assign oreg     = r_oreg;
   assign oreg_wen = r_oregWen;
   assign grant    = r_grant;

   // A held command is eligible only when its own target device is free
   assign w_elig0 = r_hold0Valid && !dev_busy[r_hold0Dev];
   assign w_elig1 = r_hold1Valid && !dev_busy[r_hold1Dev];

`ifdef PERIPH_ARBITER_LOCK_EN
   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED0  = 2'd1,
      LOCKED1  = 2'd2
   } lockState_t;

   lockState_t r_lockState;
   lockState_t w_lockNext;
   logic       r_hold0Lock;
   logic       r_hold1Lock;

   // Capture the lock bit alongside the command on acceptance
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_hold0Lock <= 1'b0;
         r_hold1Lock <= 1'b0;
      end else begin
         if (req0_valid && !r_hold0Valid) r_hold0Lock <= req0_lock;
         if (req1_valid && !r_hold1Valid) r_hold1Lock <= req1_lock;
      end
   end

   // Lock state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_lockState <= UNLOCKED;
      else        r_lockState <= w_lockNext;
   end

   // Every grant re-decides the lock from the winner's held lock bit
   always_comb begin
      w_lockNext = r_lockState;
      if (w_win0)      w_lockNext = r_hold0Lock ? LOCKED0 : UNLOCKED;
      else if (w_win1) w_lockNext = r_hold1Lock ? LOCKED1 : UNLOCKED;
   end

   assign w_allow0    = (r_lockState != LOCKED1);
   assign w_allow1    = (r_lockState != LOCKED0);
   assign w_ptrFreeze = (r_lockState != UNLOCKED);
`else
   logic w_unusedLock;
   assign w_unusedLock = req0_lock | req1_lock;
   assign w_allow0     = 1'b1;
   assign w_allow1     = 1'b1;
   assign w_ptrFreeze  = 1'b0;
`endif

   // Round-robin pick: the pointer only matters when both candidates compete
   always_comb begin
      w_cand0   = w_elig0 && w_allow0;
      w_cand1   = w_elig1 && w_allow1;
      w_win0    = w_cand0 && (!w_cand1 || !r_rrPtr);
      w_win1    = w_cand1 && (!w_cand0 || r_rrPtr);
      w_issue   = w_win0 || w_win1;
      w_winInst = w_win1 ? r_hold1Inst : r_hold0Inst;
      w_winDev  = w_win1 ? r_hold1Dev  : r_hold0Dev;
      w_winWen  = NUM_DEV'(1) << w_winDev;
   end

   // Holding registers fill on handshake and drain when their command issues
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_hold0Valid <= 1'b0;
         r_hold0Inst  <= '0;
         r_hold0Dev   <= '0;
         r_hold1Valid <= 1'b0;
         r_hold1Inst  <= '0;
         r_hold1Dev   <= '0;
      end else begin
         if (req0_valid && !r_hold0Valid) begin
            r_hold0Valid <= 1'b1;
            r_hold0Inst  <= req0_inst;
            r_hold0Dev   <= req0_dev;
         end else if (w_win0) begin
            r_hold0Valid <= 1'b0;
         end
         if (req1_valid && !r_hold1Valid) begin
            r_hold1Valid <= 1'b1;
            r_hold1Inst  <= req1_inst;
            r_hold1Dev   <= req1_dev;
         end else if (w_win1) begin
            r_hold1Valid <= 1'b0;
         end
      end
   end

   // Drive the bus from the winner; oreg holds its value when idle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_oreg    <= '0;
         r_oregWen <= '0;
         r_grant   <= 2'b00;
         r_rrPtr   <= 1'b0;
      end else begin
         if (w_issue) begin
            r_oreg    <= w_winInst;
            r_oregWen <= w_winWen;
            r_grant   <= {w_win1, w_win0};
            if (!w_ptrFreeze) r_rrPtr <= w_win0;
         end else begin
            r_oregWen <= '0;
            r_grant   <= 2'b00;
         end
      end
   end

endmodule

// File: tb/tb_periph_arbiter.sv
// tb_periph_arbiter: directed and randomized checks of periph_arbiter against
// a command-level reference model of the two holding registers and the bus.
module tb_periph_arbiter;

   logic        clock;
   logic        reset;
   logic        req0_valid;
   logic [11:0] req0_inst;
   logic [2:0]  req0_dev;
   logic        req0_lock;
   logic        req0_ready;
   logic        req1_valid;
   logic [11:0] req1_inst;
   logic [2:0]  req1_dev;
   logic        req1_lock;
   logic        req1_ready;
   logic [7:0]  dev_busy;
   logic [11:0] oreg;
   logic [7:0]  oreg_wen;
   logic [1:0]  grant;

   int compareCount = 0;
   int errCount     = 0;

   // Reference model state
   bit          mValid[2];
   logic [11:0] mInst[2];
   int          mDev[2];
   bit          mLock[2];
   int          mPtr;
   int          mOwner;
   logic [11:0] mOreg;
   logic [7:0]  mWen;
   logic [1:0]  mGrant;

   periph_arbiter #(.INST_WIDTH(12), .NUM_DEV(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_inst  (req0_inst),
      .req0_dev   (req0_dev),
      .req0_lock  (req0_lock),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_inst  (req1_inst),
      .req1_dev   (req1_dev),
      .req1_lock  (req1_lock),
      .req1_ready (req1_ready),
      .dev_busy   (dev_busy),
      .oreg       (oreg),
      .oreg_wen   (oreg_wen),
      .grant      (grant)
   );

   // Free-running clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Safety net so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         errCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit v0, input logic [11:0] i0, input logic [2:0] d0,
                                input bit l0, input bit v1, input logic [11:0] i1,
                                input logic [2:0] d1, input bit l1, input logic [7:0] busy);
      req0_valid = v0; req0_inst = i0; req0_dev = d0; req0_lock = l0;
      req1_valid = v1; req1_inst = i1; req1_dev = d1; req1_lock = l1;
      dev_busy   = busy;
   endtask

   task automatic modelReset();
      for (int n = 0; n < 2; n++) begin
         mValid[n] = 0; mInst[n] = '0; mDev[n] = 0; mLock[n] = 0;
      end
      mPtr = 0; mOwner = -1; mOreg = '0; mWen = '0; mGrant = '0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven
   task automatic modelStep();
      bit          inVal[2];
      logic [11:0] inInst[2];
      int          inDev[2];
      bit          inLock[2];
      bit          acc[2];
      bit          elig[2];
      int          w;
      bit          wasLocked;
      inVal[0] = req0_valid; inInst[0] = req0_inst; inDev[0] = int'(req0_dev); inLock[0] = req0_lock;
      inVal[1] = req1_valid; inInst[1] = req1_inst; inDev[1] = int'(req1_dev); inLock[1] = req1_lock;
      for (int n = 0; n < 2; n++) begin
         acc[n]  = inVal[n] && !mValid[n];
         elig[n] = mValid[n] && !dev_busy[mDev[n]];
         if (mOwner >= 0 && mOwner != n) elig[n] = 0;
      end
      if (elig[0] && elig[1]) w = mPtr;
      else if (elig[0])       w = 0;
      else if (elig[1])       w = 1;
      else                    w = -1;
      if (w >= 0) begin
         mOreg     = mInst[w];
         mWen      = 8'(1 << mDev[w]);
         mGrant    = 2'(1 << w);
         mValid[w] = 0;
         wasLocked = (mOwner >= 0);
`ifdef PERIPH_ARBITER_LOCK_EN
         mOwner = mLock[w] ? w : -1;
`endif
         if (!wasLocked) mPtr = 1 - w;
      end else begin
         mWen   = '0;
         mGrant = '0;
      end
      for (int n = 0; n < 2; n++) begin
         if (acc[n]) begin
            mValid[n] = 1; mInst[n] = inInst[n]; mDev[n] = inDev[n]; mLock[n] = inLock[n];
         end
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".ready0"}, 32'(req0_ready), 32'(!mValid[0]));
      checkOutput({tag, ".ready1"}, 32'(req1_ready), 32'(!mValid[1]));
      checkOutput({tag, ".oreg"},   32'(oreg),       32'(mOreg));
      checkOutput({tag, ".wen"},    32'(oreg_wen),   32'(mWen));
      checkOutput({tag, ".grant"},  32'(grant),      32'(mGrant));
   endtask

   task automatic tick(input string tag);
      modelStep();
      @(posedge clock);
      #1;
      checkAll(tag);
   endtask

   // Assert reset away from an edge, verify the asynchronous clear, release it
   task automatic doReset();
      reset = 1'b0;
      #1;
      checkOutput("rst.wen",    32'(oreg_wen),   32'h0);
      checkOutput("rst.grant",  32'(grant),      32'h0);
      checkOutput("rst.ready0", 32'(req0_ready), 32'h1);
      checkOutput("rst.ready1", 32'(req1_ready), 32'h1);
      modelReset();
      @(posedge clock);
      #1;
      checkAll("inReset");
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      logic [11:0] lockInst[3];
      bit          lockBit[3];
      logic [1:0]  gseq[4];
      logic [1:0]  gexp[4];
      int          idx;
      int          ng;
      bit          pend1;
      bit          acc0;
      bit          acc1;

      reset = 1'b0;
      applyStimulus(0, '0, '0, 0, 0, '0, '0, 0, '0);
      #2;
      doReset();

      // Single command: accept, then issue on the following edge
      applyStimulus(1, 12'h123, 3'd2, 0, 0, '0, '0, 0, 8'h00);
      tick("t1.acc");
      checkOutput("t1.ready0_low", 32'(req0_ready), 32'h0);
      applyStimulus(0, '0, '0, 0, 0, '0, '0, 0, 8'h00);
      tick("t1.iss");
      checkOutput("t1.oreg",  32'(oreg),     32'h123);
      checkOutput("t1.wen",   32'(oreg_wen), 32'h04);
      checkOutput("t1.grant", 32'(grant),    32'h1);
      tick("t1.idle");
      checkOutput("t1.ready0_high", 32'(req0_ready), 32'h1);
      checkOutput("t1.wen_idle",    32'(oreg_wen),   32'h0);
      checkOutput("t1.oreg_keep",   32'(oreg),       32'h123);

      // Both requesters streaming: bus alternates every cycle starting with req0
      doReset();
      applyStimulus(1, 12'h0A1, 3'd0, 0, 1, 12'h0B2, 3'd1, 0, 8'h00);
      tick("t2.acc");
      for (int k = 0; k < 6; k++) begin
         tick("t2.alt");
         checkOutput("t2.altwen", 32'(oreg_wen), (k % 2 == 0) ? 32'h01 : 32'h02);
      end
      applyStimulus(0, '0, '0, 0, 0, '0, '0, 0, 8'h00);
      for (int k = 0; k < 3; k++) tick("t2.drain");

      // Busy device blocks only its own command
      doReset();
      applyStimulus(1, 12'h111, 3'd1, 0, 1, 12'h333, 3'd3, 0, 8'h02);
      tick("t3.acc");
      applyStimulus(0, '0, '0, 0, 0, '0, '0, 0, 8'h02);
      tick("t3.req1");
      checkOutput("t3.wen1",   32'(oreg_wen), 32'h08);
      checkOutput("t3.grant1", 32'(grant),    32'h2);
      tick("t3.blocked");
      tick("t3.blocked");
      checkOutput("t3.wenBlocked", 32'(oreg_wen), 32'h0);
      dev_busy = 8'h00;
      tick("t3.req0");
      checkOutput("t3.wen0",  32'(oreg_wen), 32'h02);
      checkOutput("t3.oreg0", 32'(oreg),     32'h111);

      // Reset while a write is on the bus and a command is still held
      doReset();
      applyStimulus(1, 12'h444, 3'd4, 0, 1, 12'h555, 3'd5, 0, 8'h20);
      tick("t4.acc");
      applyStimulus(0, '0, '0, 0, 0, '0, '0, 0, 8'h20);
      tick("t4.iss");
      checkOutput("t4.wenBefore", 32'(oreg_wen), 32'h10);
      doReset();
      dev_busy = 8'h00;
      tick("t4.after");
      tick("t4.after");
      checkOutput("t4.wenAfter", 32'(oreg_wen), 32'h0);

      // Reset with both holding registers full
      applyStimulus(1, 12'h666, 3'd6, 0, 1, 12'h777, 3'd7, 0, 8'hFF);
      tick("t4b.acc");
      applyStimulus(0, '0, '0, 0, 0, '0, '0, 0, 8'hFF);
      tick("t4b.held");
      checkOutput("t4b.ready0Full", 32'(req0_ready), 32'h0);
      checkOutput("t4b.ready1Full", 32'(req1_ready), 32'h0);
      doReset();
      dev_busy = 8'h00;
      tick("t4b.after");
      tick("t4b.after");
      checkOutput("t4b.ready0", 32'(req0_ready), 32'h1);
      checkOutput("t4b.ready1", 32'(req1_ready), 32'h1);
      checkOutput("t4b.wen",    32'(oreg_wen),   32'h0);

      // Lock sequence from req0 while req1 has one command pending
      doReset();
      lockInst[0] = 12'h0C0; lockInst[1] = 12'h0C1; lockInst[2] = 12'h0C2;
      lockBit[0]  = 1;       lockBit[1]  = 1;       lockBit[2]  = 0;
`ifdef PERIPH_ARBITER_LOCK_EN
      gexp[0] = 2'b01; gexp[1] = 2'b01; gexp[2] = 2'b01; gexp[3] = 2'b10;
`else
      gexp[0] = 2'b01; gexp[1] = 2'b10; gexp[2] = 2'b01; gexp[3] = 2'b01;
`endif
      for (int k = 0; k < 4; k++) gseq[k] = 2'b00;
      idx = 0; ng = 0; pend1 = 1;
      for (int c = 0; c < 12; c++) begin
         applyStimulus(idx < 3, (idx < 3) ? lockInst[idx] : 12'h000, 3'd6,
                       (idx < 3) ? lockBit[idx] : 1'b0,
                       pend1, 12'h0B2, 3'd1, 0, 8'h00);
         acc0 = req0_valid && !mValid[0];
         acc1 = req1_valid && !mValid[1];
         tick("t5.lock");
         if (acc0) idx++;
         if (acc1) pend1 = 0;
         if (grant != 2'b00 && ng < 4) begin
            gseq[ng] = grant;
            ng++;
         end
      end
      for (int k = 0; k < 4; k++) checkOutput($sformatf("t5.grant%0d", k), 32'(gseq[k]), 32'(gexp[k]));

      // Randomized traffic against the model, with one reset in the middle
      doReset();
      for (int c = 0; c < 400; c++) begin
         if (c == 200) doReset();
         applyStimulus($urandom_range(0, 3) != 0, 12'($urandom), 3'($urandom), 1'($urandom),
                       $urandom_range(0, 3) != 0, 12'($urandom), 3'($urandom), 1'($urandom),
                       8'($urandom & $urandom & $urandom));
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
      $finish;
   end

endmodule
